// File: rtl/usr_mem_axil_pkg.sv
// Shared types, response codes and the byte-merge helper for the UserMemoryAccess AXI4-Lite register file.
package usr_mem_axil_pkg;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned NUM_REGS = 4;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned IDX_W    = 2;

    // One committed write, presented for a single cycle to the register array
    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              err;
    } wr_commit_t;

    function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_val,
                                                     input logic [DATA_W-1:0] new_val,
                                                     input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] res;
        for (int unsigned i = 0; i < STRB_W; i++) begin
            res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_wr_join.sv
// Order-independent AW/W capture and write-response channel; emits a one-cycle commit on the joining handshake.
module axil_wr_join
    import usr_mem_axil_pkg::*;
#(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic              commit_vld_c,
    output wr_commit_t        commit_c
);

    // Any set bit above the 16-byte window marks the access out of range
    localparam logic [ADDR_W-1:0] HI_MASK = ~ADDR_W'(4'hF);

    wr_state_t         state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [STRB_W-1:0] strb_q;
    logic              aw_hs;
    logic              w_hs;
    logic [ADDR_W-1:0] sel_addr;
    logic              unused_c;

    // Commit is the cycle the second of the two handshakes completes
    always_comb begin
        aw_hs         = awvalid && awready;
        w_hs          = wvalid && wready;
        sel_addr      = (state == W_HAVE_A) ? addr_q : awaddr;
        commit_c.idx  = sel_addr[3:2];
        commit_c.data = (state == W_HAVE_D) ? data_q : wdata;
        commit_c.strb = (state == W_HAVE_D) ? strb_q : wstrb;
        commit_c.err  = |(sel_addr & HI_MASK);
        case (state)
            W_IDLE:   commit_vld_c = aw_hs && w_hs;
            W_HAVE_A: commit_vld_c = w_hs;
            W_HAVE_D: commit_vld_c = aw_hs;
            default:  commit_vld_c = 1'b0;
        endcase
    end

    assign unused_c = ^sel_addr[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
        end else begin
            case (state)
                W_IDLE: begin
                    if (commit_vld_c) begin
                        state   <= W_RESP;
                        awready <= 1'b0;
                        wready  <= 1'b0;
                    end else if (aw_hs) begin
                        state   <= W_HAVE_A;
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        addr_q  <= awaddr;
                    end else if (w_hs) begin
                        state   <= W_HAVE_D;
                        awready <= 1'b1;
                        wready  <= 1'b0;
                        data_q  <= wdata;
                        strb_q  <= wstrb;
                    end else begin
                        awready <= 1'b1;
                        wready  <= 1'b1;
                    end
                end
                W_HAVE_A, W_HAVE_D: begin
                    if (commit_vld_c) begin
                        state   <= W_RESP;
                        awready <= 1'b0;
                        wready  <= 1'b0;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        state   <= W_IDLE;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                    end
                end
                default: state <= W_IDLE;
            endcase

            if (commit_vld_c) begin
                bvalid <= 1'b1;
                bresp  <= commit_c.err ? RESP_SLVERR : RESP_OKAY;
            end else if (state == W_RESP && bready) begin
                bvalid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/usr_mem_axil_regs.sv
// AXI4-Lite slave exposing four 32-bit user registers with per-register write strobes.
module usr_mem_axil_regs
    import usr_mem_axil_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                                   s00_axi_aclk,
    input  logic                                   s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_awaddr,
    input  logic [2:0]                             s00_axi_awprot,
    input  logic                                   s00_axi_awvalid,
    output logic                                   s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        s00_axi_wstrb,
    input  logic                                   s00_axi_wvalid,
    output logic                                   s00_axi_wready,
    output logic [1:0]                             s00_axi_bresp,
    output logic                                   s00_axi_bvalid,
    input  logic                                   s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_araddr,
    input  logic [2:0]                             s00_axi_arprot,
    input  logic                                   s00_axi_arvalid,
    output logic                                   s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_rdata,
    output logic [1:0]                             s00_axi_rresp,
    output logic                                   s00_axi_rvalid,
    input  logic                                   s00_axi_rready,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] usr_regs,
    output logic [NUM_REGS-1:0]                    usr_wr_stb
);

    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] HI_MASK = ~C_S_AXI_ADDR_WIDTH'(4'hF);
    localparam logic [NUM_REGS-1:0]           STB_ONE = NUM_REGS'(1);

    logic       commit_vld_c;
    wr_commit_t commit_c;
    rd_state_t  rd_state;
    logic [1:0] ar_idx;
    logic       ar_err;
    logic       unused_c;

    assign ar_idx   = s00_axi_araddr[3:2];
    assign ar_err   = |(s00_axi_araddr & HI_MASK);
    assign unused_c = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_araddr[1:0]};

    axil_wr_join #(
        .ADDR_W(C_S_AXI_ADDR_WIDTH)
    ) u_wr_join (
        .clk          (s00_axi_aclk),
        .rst_n        (s00_axi_aresetn),
        .awaddr       (s00_axi_awaddr),
        .awvalid      (s00_axi_awvalid),
        .awready      (s00_axi_awready),
        .wdata        (s00_axi_wdata),
        .wstrb        (s00_axi_wstrb),
        .wvalid       (s00_axi_wvalid),
        .wready       (s00_axi_wready),
        .bresp        (s00_axi_bresp),
        .bvalid       (s00_axi_bvalid),
        .bready       (s00_axi_bready),
        .commit_vld_c (commit_vld_c),
        .commit_c     (commit_c)
    );

    // Register array: updated on the same edge the write channel enters its response state
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            usr_regs   <= '0;
            usr_wr_stb <= '0;
        end else begin
            usr_wr_stb <= '0;
            if (commit_vld_c && !commit_c.err) begin
                usr_wr_stb <= STB_ONE << commit_c.idx;
                usr_regs[int'(commit_c.idx)*DATA_W +: DATA_W] <=
                    byte_merge(usr_regs[int'(commit_c.idx)*DATA_W +: DATA_W],
                               commit_c.data, commit_c.strb);
            end
        end
    end

    // Read channel: capture on AR, hold until R handshake; same-edge writes are not yet visible
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            rd_state        <= R_IDLE;
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
            s00_axi_rresp   <= RESP_OKAY;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (s00_axi_arvalid && s00_axi_arready) begin
                        rd_state        <= R_DATA;
                        s00_axi_arready <= 1'b0;
                        s00_axi_rvalid  <= 1'b1;
                        s00_axi_rdata   <= ar_err ? '0 : usr_regs[int'(ar_idx)*DATA_W +: DATA_W];
                        s00_axi_rresp   <= ar_err ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        s00_axi_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s00_axi_rready) begin
                        rd_state        <= R_IDLE;
                        s00_axi_rvalid  <= 1'b0;
                        s00_axi_arready <= 1'b1;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usr_mem_axil_regs.sv
// Directed self-checking bench for usr_mem_axil_regs with a 6-bit address bus.
module tb_usr_mem_axil_regs;

    localparam int unsigned AW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] awaddr = '0;
    logic [2:0]    awprot = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b0;
    logic [AW-1:0] araddr = '0;
    logic [2:0]    arprot = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready = 1'b0;
    logic [127:0]  usr_regs;
    logic [3:0]    usr_wr_stb;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m [4];

    usr_mem_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(AW)) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .usr_regs        (usr_regs),
        .usr_wr_stb      (usr_wr_stb)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] mreg();
        return {m[3], m[2], m[1], m[0]};
    endfunction

    // AW raised at cycle aw_dly, W at w_dly; ok requires bvalid exactly one cycle after the later handshake
    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int bdly,
                            output logic [1:0] resp, output logic [3:0] stb, output logic [127:0] regs,
                            output logic ok, output logic stable);
        logic ah, wh, aw_dn, w_dn, early;
        aw_dn = 1'b0; w_dn = 1'b0; early = 1'b0; stable = 1'b1;
        for (int c = 0; c < 40 && !(aw_dn && w_dn); c++) begin
            if (c == aw_dly) begin awvalid = 1'b1; awaddr = a; end
            if (c == w_dly) begin wvalid = 1'b1; wdata = d; wstrb = s; end
            if (bvalid) early = 1'b1;
            ah = awvalid && awready;
            wh = wvalid && wready;
            @(posedge clk); #1;
            if (ah) begin awvalid = 1'b0; aw_dn = 1'b1; end
            if (wh) begin wvalid = 1'b0; w_dn = 1'b1; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        resp = bresp; stb = usr_wr_stb; regs = usr_regs;
        ok = aw_dn && w_dn && bvalid && !early;
        for (int c = 0; c < bdly; c++) begin
            @(posedge clk); #1;
            if (!bvalid || bresp !== resp || awready || wready || usr_wr_stb !== 4'b0) stable = 1'b0;
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        if (bvalid || usr_wr_stb !== 4'b0 || !awready || !wready) ok = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int rdly,
                           output logic [31:0] d, output logic [1:0] r,
                           output logic ok, output logic stable);
        logic ah, dn;
        dn = 1'b0; stable = 1'b1;
        araddr = a; arvalid = 1'b1;
        for (int c = 0; c < 20 && !dn; c++) begin
            ah = arready;
            @(posedge clk); #1;
            if (ah) begin arvalid = 1'b0; dn = 1'b1; end
        end
        arvalid = 1'b0;
        d = rdata; r = rresp;
        ok = dn && rvalid;
        for (int c = 0; c < rdly; c++) begin
            @(posedge clk); #1;
            if (!rvalid || rdata !== d || rresp !== r || arready) stable = 1'b0;
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        if (rvalid || !arready) ok = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({awready, wready, arready} !== 3'b000) begin
            n_bad++; $display("FAIL reset_ready: got %b want 000", {awready, wready, arready});
        end
        n_cmp++;
        if ({bvalid, rvalid, bresp, rresp, usr_wr_stb} !== 10'b0 || rdata !== 32'h0 || usr_regs !== 128'h0) begin
            n_bad++; $display("FAIL reset_outputs: got bv=%b rv=%b regs=%h rdata=%h", bvalid, rvalid, usr_regs, rdata);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({awready, wready, arready} !== 3'b111) begin
            n_bad++; $display("FAIL reset_release_ready: got %b want 111", {awready, wready, arready});
        end
    endtask

    task automatic test_sequential();
        logic [1:0] resp; logic [3:0] stb, es; logic [127:0] regs; logic ok, st; logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            do_write(AW'(4*i), 32'(i + 1), 4'hF, 0, 0, 0, resp, stb, regs, ok, st);
            m[i] = 32'(i + 1);
            es = 4'b0001 << i;
            n_cmp++;
            if (!ok || resp !== 2'b00 || stb !== es || regs !== mreg()) begin
                n_bad++; $display("FAIL seq_write[%0d]: ok=%b resp=%b stb=%b regs=%h want stb=%b regs=%h", i, ok, resp, stb, regs, es, mreg());
            end
        end
        for (int i = 0; i < 4; i++) begin
            do_read(AW'(4*i), 0, d, resp, ok, st);
            n_cmp++;
            if (!ok || resp !== 2'b00 || d !== 32'(i + 1)) begin
                n_bad++; $display("FAIL seq_read[%0d]: ok=%b resp=%b data=%h want %h", i, ok, resp, d, i + 1);
            end
        end
    endtask

    task automatic test_order();
        logic [1:0] resp; logic [3:0] stb; logic [127:0] regs; logic ok, st;
        do_write(6'h08, 32'hDEADBEEF, 4'hF, 3, 0, 0, resp, stb, regs, ok, st);
        m[2] = 32'hDEADBEEF;
        n_cmp++;
        if (!ok || stb !== 4'b0100 || regs !== mreg()) begin
            n_bad++; $display("FAIL order_w_first: ok=%b stb=%b regs=%h want %h", ok, stb, regs, mreg());
        end
        do_write(6'h08, 32'h0, 4'hF, 0, 0, 0, resp, stb, regs, ok, st);
        m[2] = 32'h0;
        do_write(6'h08, 32'hDEADBEEF, 4'hF, 0, 3, 0, resp, stb, regs, ok, st);
        m[2] = 32'hDEADBEEF;
        n_cmp++;
        if (!ok || stb !== 4'b0100 || regs !== mreg()) begin
            n_bad++; $display("FAIL order_aw_first: ok=%b stb=%b regs=%h want %h", ok, stb, regs, mreg());
        end
    endtask

    task automatic test_strobes();
        logic [1:0] resp; logic [3:0] stb; logic [127:0] regs; logic ok, st;
        do_write(6'h04, 32'h11223344, 4'hF, 0, 0, 0, resp, stb, regs, ok, st);
        do_write(6'h04, 32'hAABBCCDD, 4'b0101, 0, 0, 0, resp, stb, regs, ok, st);
        m[1] = 32'h11BB33DD;
        n_cmp++;
        if (!ok || regs !== mreg()) begin
            n_bad++; $display("FAIL strb_0101: ok=%b regs=%h want %h", ok, regs, mreg());
        end
        do_write(6'h04, 32'hFFFFFFFF, 4'b0000, 0, 0, 0, resp, stb, regs, ok, st);
        n_cmp++;
        if (!ok || resp !== 2'b00 || stb !== 4'b0010 || regs !== mreg()) begin
            n_bad++; $display("FAIL strb_zero: ok=%b resp=%b stb=%b regs=%h want stb=0010 regs=%h", ok, resp, stb, regs, mreg());
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] resp; logic [3:0] stb; logic [127:0] regs; logic ok, st; logic [31:0] d;
        do_write(6'h0C, 32'hCAFEF00D, 4'hF, 0, 0, 5, resp, stb, regs, ok, st);
        m[3] = 32'hCAFEF00D;
        n_cmp++;
        if (!ok || !st || resp !== 2'b00 || regs !== mreg()) begin
            n_bad++; $display("FAIL bp_write: ok=%b stable=%b resp=%b regs=%h want %h", ok, st, resp, regs, mreg());
        end
        do_read(6'h0C, 5, d, resp, ok, st);
        n_cmp++;
        if (!ok || !st || resp !== 2'b00 || d !== 32'hCAFEF00D) begin
            n_bad++; $display("FAIL bp_read: ok=%b stable=%b resp=%b data=%h want cafef00d", ok, st, resp, d);
        end
    endtask

    task automatic test_simultaneous();
        n_cmp++;
        if ({awready, wready, arready} !== 3'b111) begin
            n_bad++; $display("FAIL simul_ready: got %b want 111", {awready, wready, arready});
        end
        awaddr = 6'h00; wdata = 32'h55AA55AA; wstrb = 4'hF; araddr = 6'h00;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        n_cmp++;
        if (!rvalid || rdata !== m[0]) begin
            n_bad++; $display("FAIL simul_rdata: rvalid=%b data=%h want %h", rvalid, rdata, m[0]);
        end
        m[0] = 32'h55AA55AA;
        n_cmp++;
        if (!bvalid || usr_wr_stb !== 4'b0001 || usr_regs !== mreg()) begin
            n_bad++; $display("FAIL simul_write: bvalid=%b stb=%b regs=%h want %h", bvalid, usr_wr_stb, usr_regs, mreg());
        end
        bready = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0; rready = 1'b0;
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp; logic [3:0] stb; logic [127:0] regs; logic ok, st; logic [31:0] d;
        do_write(6'h10, 32'hFFFFFFFF, 4'hF, 0, 0, 0, resp, stb, regs, ok, st);
        n_cmp++;
        if (!ok || resp !== 2'b10 || stb !== 4'b0000 || regs !== mreg()) begin
            n_bad++; $display("FAIL oor_write: ok=%b resp=%b stb=%b regs=%h want resp=10 regs=%h", ok, resp, stb, regs, mreg());
        end
        do_read(6'h20, 0, d, resp, ok, st);
        n_cmp++;
        if (!ok || resp !== 2'b10 || d !== 32'h0) begin
            n_bad++; $display("FAIL oor_read: ok=%b resp=%b data=%h want resp=10 data=0", ok, resp, d);
        end
        do_read(6'h03, 0, d, resp, ok, st);
        n_cmp++;
        if (!ok || resp !== 2'b00 || d !== m[0]) begin
            n_bad++; $display("FAIL low_bits_ignored: ok=%b resp=%b data=%h want %h", ok, resp, d, m[0]);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [1:0] resp; logic ok, st; logic [31:0] d;
        awaddr = 6'h00; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) m[i] = 32'h0;
        n_cmp++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || usr_regs !== 128'h0 || usr_wr_stb !== 4'b0) begin
            n_bad++; $display("FAIL rst_mid_async: rdy=%b bv=%b rv=%b regs=%h", {awready, wready, arready}, bvalid, rvalid, usr_regs);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({awready, wready, bvalid} !== 3'b110) begin
            n_bad++; $display("FAIL rst_mid_release: aw=%b w=%b bv=%b want 1 1 0", awready, wready, bvalid);
        end
        do_read(6'h00, 0, d, resp, ok, st);
        n_cmp++;
        if (!ok || resp !== 2'b00 || d !== 32'h0 || usr_regs !== 128'h0) begin
            n_bad++; $display("FAIL rst_mid_read: ok=%b data=%h regs=%h want 0", ok, d, usr_regs);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m[i] = 32'h0;
        test_reset();
        test_sequential();
        test_order();
        test_strobes();
        test_backpressure();
        test_simultaneous();
        test_out_of_range();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
